// File: rtl/sram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_arbiter_pkg
// Shared definitions for the I/D SRAM-bus arbiter:
//   - requester ID constants (ID FIFO entry encoding)
//   - SRAM size encodings
//   - request bundle layout and width (wr + size + addr + wstrb + wdata)
//   - helper to build a request bundle from discrete port fields
// -----------------------------------------------------------------------------
package sram_arbiter_pkg;

   localparam logic ARB_ID_INST = 1'b0;
   localparam logic ARB_ID_DATA = 1'b1;

   typedef enum logic [1:0] {
      SRAM_SIZE_1B = 2'd0,
      SRAM_SIZE_2B = 2'd1,
      SRAM_SIZE_4B = 2'd2
   } sram_size_e;

   localparam int ARB_REQ_W = 71;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } arb_req_t;

   function automatic arb_req_t arb_pack_req(
      input logic        wr,
      input logic [1:0]  size,
      input logic [31:0] addr,
      input logic [3:0]  wstrb,
      input logic [31:0] wdata
   );
      arb_req_t r;
      r.wr    = wr;
      r.size  = size;
      r.addr  = addr;
      r.wstrb = wstrb;
      r.wdata = wdata;
      return r;
   endfunction

endpackage

// File: rtl/sram_arbiter_chk.sv
// -----------------------------------------------------------------------------
// sram_arbiter_chk
// Protocol checker for sram_arbiter: a downstream response arriving while no
// transaction is outstanding is a protocol error. The arbiter drops it; this
// checker only reports it.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   m_data_ok_i   downstream response valid
//   fifo_empty_i  ID FIFO empty flag
// -----------------------------------------------------------------------------
module sram_arbiter_chk (
   input logic clk,
   input logic reset,
   input logic m_data_ok_i,
   input logic fifo_empty_i
);

   // Flag responses with nothing outstanding.
   always_ff @(posedge clk) begin
      if (!reset && m_data_ok_i) begin
         assert (!fifo_empty_i)
            else $warning("sram_arbiter: m_data_ok with no outstanding transaction, response dropped");
      end
   end

endmodule

// File: rtl/sram_arbiter_id_fifo.sv
// -----------------------------------------------------------------------------
// arb_id_fifo
// Synchronous FIFO of 1-bit requester IDs, recording the owner of every
// accepted-but-unanswered address in acceptance order.
// Ports:
//   clk, reset      clock, synchronous active-high reset (empties FIFO)
//   push_i, din_i   enqueue din_i (ignored when full)
//   pop_i           dequeue head (ignored when empty)
//   dout_o          current head entry
//   full_o, empty_o occupancy flags, derived from registered count only
// -----------------------------------------------------------------------------
module arb_id_fifo #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic push_i,
   input  logic din_i,
   input  logic pop_i,
   output logic dout_o,
   output logic full_o,
   output logic empty_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [DEPTH-1:0] mem_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full_o    = (cnt_q == CNT_W'(DEPTH));
   assign empty_o   = (cnt_q == CNT_W'(0));
   assign dout_o    = mem_q[rd_ptr_q];
   assign push_ok_s = push_i & ~full_o;
   assign pop_ok_s  = pop_i & ~empty_o;

   // Storage, pointers (wrap naturally since DEPTH is a power of 2) and count.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_ok_s) begin
            mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Shares one SRAM-like bus between the instruction-fetch requester (I) and the
// load/store requester (D). Grants address handshakes, records the winner in
// an in-order ID FIFO and steers each downstream response back to its owner.
// Optional build macro:
//   ARB_RR_EN  defined   -> round-robin when both request and no lock is held
//              undefined -> fixed D > I priority
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   i_* / d_*  request group in        req, wr, size, addr, wstrb, wdata
//   i_* / d_*  handshakes out          addr_ok, data_ok, rdata
//   m_*        downstream request out  req, wr, size, addr, wstrb, wdata
//   m_addr_ok, m_data_ok, m_rdata      downstream handshakes in
// Parameter:
//   OUTST_DEPTH  max outstanding transactions (power of 2, >= 2)
// -----------------------------------------------------------------------------
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int OUTST_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic        i_wr,
   input  logic [1:0]  i_size,
   input  logic [31:0] i_addr,
   input  logic [3:0]  i_wstrb,
   input  logic [31:0] i_wdata,
   output logic        i_addr_ok,
   output logic        i_data_ok,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [1:0]  d_size,
   input  logic [31:0] d_addr,
   input  logic [3:0]  d_wstrb,
   input  logic [31:0] d_wdata,
   output logic        d_addr_ok,
   output logic        d_data_ok,
   output logic [31:0] d_rdata,
   output logic        m_req,
   output logic        m_wr,
   output logic [1:0]  m_size,
   output logic [31:0] m_addr,
   output logic [3:0]  m_wstrb,
   output logic [31:0] m_wdata,
   input  logic        m_addr_ok,
   input  logic        m_data_ok,
   input  logic [31:0] m_rdata
);

   logic     lock_valid_q, lock_valid_d;
   logic     lock_id_q, lock_id_d;
   logic     grant_s;
   logic     sel_req_s;
   arb_req_t i_bundle_s, d_bundle_s, m_bundle_s;
   logic     hs_s;
   logic     pop_s;
   logic     fifo_full_s, fifo_empty_s, fifo_head_s;

`ifdef ARB_RR_EN
   logic     rr_last_q, rr_last_d;
`endif

   assign i_bundle_s = arb_pack_req(i_wr, i_size, i_addr, i_wstrb, i_wdata);
   assign d_bundle_s = arb_pack_req(d_wr, d_size, d_addr, d_wstrb, d_wdata);

   // Grant selection: a held lock wins, otherwise priority (or round-robin).
   always_comb begin
      grant_s = ARB_ID_INST;
      if (lock_valid_q) begin
         grant_s = lock_id_q;
      end else if (d_req && i_req) begin
`ifdef ARB_RR_EN
         grant_s = (rr_last_q == ARB_ID_INST) ? ARB_ID_DATA : ARB_ID_INST;
`else
         grant_s = ARB_ID_DATA;
`endif
      end else if (d_req) begin
         grant_s = ARB_ID_DATA;
      end else begin
         grant_s = ARB_ID_INST;
      end
   end

   // Downstream request mux; all fields forced low during reset.
   always_comb begin
      sel_req_s  = 1'b0;
      m_bundle_s = '0;
      if (reset) begin
         sel_req_s  = 1'b0;
         m_bundle_s = '0;
      end else if (grant_s == ARB_ID_DATA) begin
         sel_req_s  = d_req;
         m_bundle_s = d_bundle_s;
      end else begin
         sel_req_s  = i_req;
         m_bundle_s = i_bundle_s;
      end
   end

   // Full blocks m_req regardless of a same-cycle pop: keeps m_data_ok off the m_req path.
   assign m_req   = sel_req_s & ~fifo_full_s;
   assign m_wr    = m_bundle_s.wr;
   assign m_size  = m_bundle_s.size;
   assign m_addr  = m_bundle_s.addr;
   assign m_wstrb = m_bundle_s.wstrb;
   assign m_wdata = m_bundle_s.wdata;

   assign hs_s      = m_req & m_addr_ok;
   assign i_addr_ok = hs_s & (grant_s == ARB_ID_INST);
   assign d_addr_ok = hs_s & (grant_s == ARB_ID_DATA);

   // A response with an empty FIFO is dropped: no pop, no data_ok.
   assign pop_s     = m_data_ok & ~fifo_empty_s & ~reset;
   assign i_data_ok = pop_s & (fifo_head_s == ARB_ID_INST);
   assign d_data_ok = pop_s & (fifo_head_s == ARB_ID_DATA);
   assign i_rdata   = i_data_ok ? m_rdata : 32'h0000_0000;
   assign d_rdata   = d_data_ok ? m_rdata : 32'h0000_0000;

   // Lock next state: hold the grant from an unaccepted request until its handshake.
   always_comb begin
      lock_valid_d = lock_valid_q;
      lock_id_d    = lock_id_q;
      if (hs_s) begin
         lock_valid_d = 1'b0;
      end else if (m_req && !m_addr_ok) begin
         lock_valid_d = 1'b1;
         lock_id_d    = grant_s;
      end else begin
         lock_valid_d = lock_valid_q;
         lock_id_d    = lock_id_q;
      end
   end

   // Lock registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         lock_valid_q <= 1'b0;
         lock_id_q    <= ARB_ID_INST;
      end else begin
         lock_valid_q <= lock_valid_d;
         lock_id_q    <= lock_id_d;
      end
   end

`ifdef ARB_RR_EN
   // Round-robin pointer next state: remembers who the last handshake served.
   always_comb begin
      rr_last_d = rr_last_q;
      if (hs_s) begin
         rr_last_d = grant_s;
      end else begin
         rr_last_d = rr_last_q;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_last_q <= ARB_ID_INST;
      end else begin
         rr_last_q <= rr_last_d;
      end
   end
`endif

   arb_id_fifo #(
      .DEPTH (OUTST_DEPTH)
   ) u_id_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (hs_s),
      .din_i   (grant_s),
      .pop_i   (pop_s),
      .dout_o  (fifo_head_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s)
   );

   sram_arbiter_chk u_chk (
      .clk          (clk),
      .reset        (reset),
      .m_data_ok_i  (m_data_ok),
      .fifo_empty_i (fifo_empty_s)
   );

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
// Directed self-checking bench for sram_arbiter (OUTST_DEPTH = 4). Expected
// grant order depends on whether ARB_RR_EN is defined.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

   logic        clk;
   logic        reset;
   logic        i_req, i_wr, d_req, d_wr;
   logic [1:0]  i_size, d_size;
   logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
   logic [3:0]  i_wstrb, d_wstrb;
   logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
   logic [31:0] i_rdata, d_rdata;
   logic        m_req, m_wr;
   logic [1:0]  m_size;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_addr_ok, m_data_ok;
   logic [31:0] m_rdata;

   int n_checks;
   int n_errors;

   sram_arbiter #(.OUTST_DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr),
      .i_wstrb(i_wstrb), .i_wdata(i_wdata),
      .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
      .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
      .d_wstrb(d_wstrb), .d_wdata(d_wdata),
      .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
      .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
      .m_wstrb(m_wstrb), .m_wdata(m_wdata),
      .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Inputs settle at +1, outputs are sampled at +3 (well clear of the edge).
   task automatic settle();
      #2;
   endtask

   // Check grant outcome of a cycle with m_addr_ok=1: who got addr_ok, which address went out.
   task automatic chk_grant(input string tag, input logic exp_d, input logic [31:0] exp_addr);
      chk({tag, "_m_addr"}, m_addr, exp_addr);
      chk({tag, "_d_addr_ok"}, {31'd0, d_addr_ok}, {31'd0, exp_d});
      chk({tag, "_i_addr_ok"}, {31'd0, i_addr_ok}, {31'd0, ~exp_d});
   endtask

   // Check routing of a response with data value v to requester (1=D, 0=I).
   task automatic chk_resp(input string tag, input logic to_d, input logic [31:0] v);
      chk({tag, "_d_data_ok"}, {31'd0, d_data_ok}, {31'd0, to_d});
      chk({tag, "_i_data_ok"}, {31'd0, i_data_ok}, {31'd0, ~to_d});
      chk({tag, "_d_rdata"}, d_rdata, to_d ? v : 32'h0000_0000);
      chk({tag, "_i_rdata"}, i_rdata, to_d ? 32'h0000_0000 : v);
   endtask

   // Expected grant sequence when both requesters ask in 4 consecutive cycles.
   logic exp_both [4];

   initial begin
      n_checks = 0;
      n_errors = 0;
`ifdef ARB_RR_EN
      exp_both = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      exp_both = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      reset = 1'b1;
      i_req = 1'b0; i_wr = 1'b0; i_size = 2'd2; i_addr = 32'h0; i_wstrb = 4'hf; i_wdata = 32'h0;
      d_req = 1'b0; d_wr = 1'b0; d_size = 2'd2; d_addr = 32'h0; d_wstrb = 4'hf; d_wdata = 32'h0;
      m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'h0;
      cyc();

      // ---- Reset: everything low even with live inputs ----
      i_req = 1'b1; i_addr = 32'h1c00_0000; d_req = 1'b1; d_addr = 32'h0000_8000;
      m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'hffff_ffff;
      settle();
      chk("rst_m_req", {31'd0, m_req}, 32'd0);
      chk("rst_m_addr", m_addr, 32'd0);
      chk("rst_addr_ok", {30'd0, i_addr_ok, d_addr_ok}, 32'd0);
      chk("rst_data_ok", {30'd0, i_data_ok, d_data_ok}, 32'd0);
      chk("rst_rdata", i_rdata | d_rdata, 32'd0);
      cyc();
      reset = 1'b0; i_req = 1'b0; d_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'h0;
      settle();
      chk("idle_m_req", {31'd0, m_req}, 32'd0);
      cyc();

      // ---- I-only traffic, response one cycle after each handshake ----
      i_req = 1'b1; i_addr = 32'h1c00_0000; m_addr_ok = 1'b1;
      settle();
      chk("i1_m_req", {31'd0, m_req}, 32'd1);
      chk_grant("i1", 1'b0, 32'h1c00_0000);
      cyc();
      i_addr = 32'h1c00_0004; m_data_ok = 1'b1; m_rdata = 32'h1234_5678;
      settle();
      chk_grant("i2", 1'b0, 32'h1c00_0004);
      chk_resp("i1r", 1'b0, 32'h1234_5678);
      cyc();
      i_req = 1'b0; m_addr_ok = 1'b0;
      settle();
      chk_resp("i2r", 1'b0, 32'h1234_5678);
      cyc();
      m_data_ok = 1'b0;
      settle();
      chk("i_done_m_req", {31'd0, m_req}, 32'd0);
      cyc();

      // ---- Both request for 4 cycles; each cycle also answers the previous one ----
      i_req = 1'b1; i_addr = 32'h1c00_0008; d_req = 1'b1; d_addr = 32'h0000_8000; m_addr_ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
         m_data_ok = (k != 0);
         m_rdata   = 32'h0000_0100 + 32'(k);
         settle();
         chk_grant($sformatf("both%0d", k), exp_both[k], exp_both[k] ? 32'h0000_8000 : 32'h1c00_0008);
         if (k != 0) chk_resp($sformatf("both%0dr", k), exp_both[k-1], 32'h0000_0100 + 32'(k));
         cyc();
      end
      d_req = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h0000_0200;
      settle();
      chk_grant("i_after_d", 1'b0, 32'h1c00_0008);
      chk_resp("both3r", exp_both[3], 32'h0000_0200);
      cyc();
      i_req = 1'b0; m_addr_ok = 1'b0; m_rdata = 32'h0000_0201;
      settle();
      chk_resp("i_after_dr", 1'b0, 32'h0000_0201);
      cyc();
      m_data_ok = 1'b0;

      // ---- D locked: m_addr_ok low 3 cycles, I raises req meanwhile ----
      d_req = 1'b1; d_addr = 32'h0000_8000; i_addr = 32'h1c00_0010;
      for (int k = 0; k < 3; k++) begin
         i_req = (k != 0);
         settle();
         chk($sformatf("dlock%0d_m_addr", k), m_addr, 32'h0000_8000);
         chk($sformatf("dlock%0d_i_addr_ok", k), {31'd0, i_addr_ok}, 32'd0);
         cyc();
      end
      m_addr_ok = 1'b1;
      settle();
      chk_grant("dlock_hs", 1'b1, 32'h0000_8000);
      cyc();
      // ---- I locked: D raising req must not preempt ----
      d_req = 1'b0; m_addr_ok = 1'b0;
      settle();
      chk("ilock0_m_addr", m_addr, 32'h1c00_0010);
      cyc();
      d_req = 1'b1; d_addr = 32'h0000_8004;
      settle();
      chk("ilock1_m_addr", m_addr, 32'h1c00_0010);
      chk("ilock1_d_addr_ok", {31'd0, d_addr_ok}, 32'd0);
      cyc();
      m_addr_ok = 1'b1;
      settle();
      chk_grant("ilock_hs", 1'b0, 32'h1c00_0010);
      cyc();
      i_req = 1'b0; d_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h0000_00d1;
      settle();
      chk_resp("lock_r0", 1'b1, 32'h0000_00d1);
      cyc();
      m_rdata = 32'h0000_00e1;
      settle();
      chk_resp("lock_r1", 1'b0, 32'h0000_00e1);
      cyc();
      m_data_ok = 1'b0;

      // ---- Full: 4 handshakes without response, 5th blocked ----
      i_req = 1'b1; m_addr_ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
         i_addr = 32'h1c00_0100 + 32'(4 * k);
         settle();
         chk($sformatf("fill%0d_i_addr_ok", k), {31'd0, i_addr_ok}, 32'd1);
         cyc();
      end
      i_addr = 32'h1c00_0110; m_data_ok = 1'b1; m_rdata = 32'h0000_f000;
      settle();
      chk("full_m_req", {31'd0, m_req}, 32'd0);
      chk("full_i_addr_ok", {31'd0, i_addr_ok}, 32'd0);
      chk_resp("full_pop", 1'b0, 32'h0000_f000);
      cyc();
      m_data_ok = 1'b0;
      settle();
      chk("refill_m_req", {31'd0, m_req}, 32'd1);
      chk("refill_i_addr_ok", {31'd0, i_addr_ok}, 32'd1);
      cyc();
      i_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
         m_rdata = 32'h0000_f001 + 32'(k);
         settle();
         chk_resp($sformatf("drain%0d", k), 1'b0, 32'h0000_f001 + 32'(k));
         cyc();
      end
      m_data_ok = 1'b0;

      // ---- Order I, D, I then responses A, B, C ----
      m_addr_ok = 1'b1;
      i_req = 1'b1; i_addr = 32'h1c00_0200;
      cyc();
      i_req = 1'b0; d_req = 1'b1; d_addr = 32'h0000_9000;
      cyc();
      d_req = 1'b0; i_req = 1'b1; i_addr = 32'h1c00_0204;
      cyc();
      i_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
      m_rdata = 32'h0000_000a;
      settle();
      chk_resp("ord_a", 1'b0, 32'h0000_000a);
      cyc();
      m_rdata = 32'h0000_000b;
      settle();
      chk_resp("ord_b", 1'b1, 32'h0000_000b);
      cyc();
      m_rdata = 32'h0000_000c;
      settle();
      chk_resp("ord_c", 1'b0, 32'h0000_000c);
      cyc();
      m_data_ok = 1'b0;

      // ---- Reset with 2 outstanding (D then I), then a stray response ----
      m_addr_ok = 1'b1;
      d_req = 1'b1; d_addr = 32'h0000_a000;
      cyc();
      d_req = 1'b0; i_req = 1'b1; i_addr = 32'h1c00_0300;
      cyc();
      i_req = 1'b0; m_addr_ok = 1'b0; reset = 1'b1;
      settle();
      chk("midrst_m_req", {31'd0, m_req}, 32'd0);
      cyc();
      reset = 1'b0; m_data_ok = 1'b1; m_rdata = 32'hdead_beef;
      settle();
      chk("stray_data_ok", {30'd0, i_data_ok, d_data_ok}, 32'd0);
      chk("stray_rdata", i_rdata | d_rdata, 32'd0);
      cyc();
      m_data_ok = 1'b0; i_req = 1'b1; i_addr = 32'h1c00_0400; m_addr_ok = 1'b1;
      settle();
      chk("post_rst_i_addr_ok", {31'd0, i_addr_ok}, 32'd1);
      cyc();
      i_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h0000_0777;
      settle();
      chk_resp("post_rst_r", 1'b0, 32'h0000_0777);
      cyc();
      m_rdata = 32'h0000_0888;
      settle();
      chk("post_rst_empty", {30'd0, i_data_ok, d_data_ok}, 32'd0);
      cyc();
      m_data_ok = 1'b0;
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one SRAM-like bus between the instruction-fetch requester (I) and the load/store requester (D). The downstream bus feeds the AXI bridge.
- Arbitrates address handshakes and records the winner's ID in an in-order ID FIFO.
- Routes each returning data_ok/rdata to the requester that issued the matching address.
- Downstream responses are strictly in order of accepted addresses.

Parameters:
- OUTST_DEPTH, 4, max accepted-but-unanswered transactions (ID FIFO depth, power of 2, ≥2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req  in  1  I request
- i_wr  in  1  I write (tied 0 by IF, still forwarded)
- i_size  in  2  I size (0=1B, 1=2B, 2=4B)
- i_addr  in  32  I address
- i_wstrb  in  4  I byte strobes
- i_wdata  in  32  I write data
- i_addr_ok  out  1  I address accepted
- i_data_ok  out  1  I response valid
- i_rdata  out  32  I read data
- d_req, d_wr, d_size, d_addr, d_wstrb, d_wdata  in  1/1/2/32/4/32  D request group, same meaning as I
- d_addr_ok, d_data_ok  out  1  D handshakes
- d_rdata  out  32  D read data
- m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata  out  1/1/2/32/4/32  downstream request group
- m_addr_ok  in  1  downstream address accepted
- m_data_ok  in  1  downstream response valid
- m_rdata  in  32  downstream read data

Behaviour:
- Reset: ID FIFO empty, lock cleared, RR pointer = I. Every output low while reset is high, including m_req, all addr_ok/data_ok, and zero rdata.
- Grant selection is combinational from {lock, i_req, d_req}:
  - If lock_valid, grant = lock_id.
  - Otherwise fixed priority D > I.
- m_req = granted requester's req & ~fifo_full & ~reset. All m_* request fields are muxed from the granted requester.
- Addr handshake:
  - Granted requester's addr_ok = m_addr_ok & m_req; the other requester's addr_ok = 0.
  - On handshake, push grant ID (0=I, 1=D) into the FIFO the same cycle.
- Lock:
  - Set when m_req=1 and m_addr_ok=0; lock_id = current grant.
  - Cleared on the handshake cycle.
  - Keeps the request fields stable across addr_ok wait, so the other requester cannot preempt.
  - If the locked requester drops req, the lock is still held until a handshake occurs. Requesters must not withdraw req before addr_ok, as the IF stage already guarantees.
- Response:
  - When m_data_ok=1, the FIFO head selects the destination: that requester's data_ok=1 and rdata=m_rdata, same cycle (0-cycle latency). The other requester's rdata = 0.
  - FIFO pops the same cycle.
- Simultaneous push and pop: both happen; occupancy unchanged.
- Full: FIFO full blocks m_req even if a pop occurs the same cycle, which avoids a combinational path from m_data_ok to m_req.
- Empty + m_data_ok: protocol error. Response dropped, no pop, no requester data_ok. A simulation assertion fires.
- Cancelled IF requests still get their data_ok. The IF stage relies on its own outstanding counter, so the arbiter never discards a response.
- Occupancy counter is log2(OUTST_DEPTH)+1 bits. Read/write pointers wrap modulo OUTST_DEPTH.
- Reset mid-transaction: FIFO and lock are cleared. Later stray m_data_ok is handled per the empty rule.

Optional Feature:
- ARB_RR_EN defined: round-robin between I and D when both request and no lock is held. The winner is the requester not served by the last handshake; the pointer updates on each handshake.
- ARB_RR_EN undefined: fixed D > I priority, no pointer register.

Decomposition:
- Shared package/header holds:
  - requester ID constants ARB_ID_INST=0, ARB_ID_DATA=1
  - SRAM size encodings
  - request bundle width constant (71 bits = wr+size+addr+wstrb+wdata)
- One sub-module, arb_id_fifo: synchronous FIFO of 1-bit entries with push/pop/full/empty. All flags are registered-state derived.

Test Plan:
- Only I requests, addr 0x1c000000/0x1c000004, m_addr_ok=1, m_data_ok one cycle later with 0x12345678 -> i_data_ok pulses each time, i_rdata=0x12345678, d_data_ok stays 0.
- i_req and d_req together, no RR -> D (addr 0x8000) granted first, then I. With ARB_RR_EN, grants alternate D,I,D,I over 4 handshakes.
- D granted, m_addr_ok held 0 for 3 cycles while I raises req -> m_addr stays 0x8000 and i_addr_ok=0 until D handshakes.
- OUTST_DEPTH=4, 4 handshakes with no data_ok -> m_req=0 on the 5th. With m_data_ok in that cycle, m_req rises the next cycle.
- Order I,D,I accepted, three m_data_ok with 0xA/0xB/0xC -> i gets 0xA, d gets 0xB, i gets 0xC.
- Reset asserted with 2 outstanding, then m_data_ok -> no data_ok on either requester, assertion logged, FIFO remains empty.
